// File: rtl/amt_smt_restore_pkg.sv
// Shared definitions for the multi-thread architectural map table (AMT) and
// its rollback-restore engine: default geometry, retire-write, table-entry and
// restore-beat types, the FSM state type, and the reset-tag helper.

`ifndef AMT_RESTORE_PER_CYCLE
`define AMT_RESTORE_PER_CYCLE 8
`endif

package amt_smt_restore_pkg;

  localparam int RT_NUM            = 2;
  localparam int ARCH_REG_NUM      = 32;
  localparam int TAG_IDX_WIDTH     = 6;
  localparam int THREAD_NUM        = 2;
  localparam int THREAD_IDX_WIDTH  = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;
  localparam int ARCH_IDX_WIDTH    = $clog2(ARCH_REG_NUM);
  localparam int RESTORE_PER_CYCLE = `AMT_RESTORE_PER_CYCLE;

  typedef logic [TAG_IDX_WIDTH-1:0] AMT_ENTRY;
  typedef AMT_ENTRY                 AMT_OUTPUT;

  typedef struct packed {
    logic                      wr_en;
    logic [ARCH_IDX_WIDTH-1:0] arch_reg;
    logic [TAG_IDX_WIDTH-1:0]  phy_reg;
  } ROB_AMT;

  typedef struct packed {
    logic [THREAD_IDX_WIDTH-1:0]                        thread;
    logic [ARCH_IDX_WIDTH-1:0]                          base;
    logic                                               last;
    logic [RESTORE_PER_CYCLE-1:0][TAG_IDX_WIDTH-1:0]    tag;
  } AMT_RESTORE_BEAT;

  typedef enum logic {
    RST_IDLE   = 1'b0,
    RST_STREAM = 1'b1
  } restore_state_e;

  // Each thread owns a disjoint block of physical tags after reset; arch 0 is
  // the hard-wired zero register and always maps to tag 0.
  function automatic AMT_ENTRY reset_tag(input int thr_idx, input int arch_idx,
                                         input int arch_num);
    if (arch_idx == 0) return '0;
    return AMT_ENTRY'(arch_idx + thr_idx * (arch_num - 1));
  endfunction

endpackage

// File: rtl/amt_smt_restore_bank.sv
// One hardware thread's committed arch->phys table.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   wr_i           : C_RT_NUM retire writes for this thread
//   entry_o        : registered table contents, one tag per arch register

module amt_smt_restore_bank
  import amt_smt_restore_pkg::*;
#(
  parameter int C_RT_NUM       = RT_NUM,
  parameter int C_ARCH_REG_NUM = ARCH_REG_NUM,
  parameter int C_THREAD_ID    = 0
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  ROB_AMT   wr_i    [C_RT_NUM],
  output AMT_ENTRY entry_o [C_ARCH_REG_NUM]
);

  AMT_ENTRY entry_q [C_ARCH_REG_NUM];
  AMT_ENTRY entry_d [C_ARCH_REG_NUM];

  // Channels are applied in ascending order so the highest (youngest)
  // channel overwrites older ones hitting the same arch register.
  always_comb begin
    for (int i = 0; i < C_ARCH_REG_NUM; i++) begin
      entry_d[i] = entry_q[i];
    end
    for (int c = 0; c < C_RT_NUM; c++) begin
      if (wr_i[c].wr_en && (wr_i[c].arch_reg != '0)) begin
        entry_d[wr_i[c].arch_reg] = wr_i[c].phy_reg;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < C_ARCH_REG_NUM; i++) begin
        entry_q[i] <= reset_tag(C_THREAD_ID, i, C_ARCH_REG_NUM);
      end
    end else begin
      for (int i = 0; i < C_ARCH_REG_NUM; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/amt_smt_restore.sv
// Multi-thread architectural map table with a sequenced rollback-restore
// engine. Retiring ROB entries update one committed table per thread; a
// rollback request streams that thread's table to the rename map table over a
// valid/ready channel, C_RESTORE_PER_CYCLE entries per beat.
// Ports:
//   clk_i, rst_n_i    : clock, asynchronous active-low reset
//   rob_amt_i         : per-thread, per-channel retire writes
//   rollback_i        : per-thread rollback request pulse
//   amt_o             : registered committed tables
//   thread_busy_o     : thread has a rollback pending or streaming
//   restore_valid_o   : restore beat valid
//   restore_ready_i   : map table accepts the beat
//   restore_thread_o  : thread being restored
//   restore_base_o    : arch index of tag[0] in this beat
//   restore_tag_o     : tags for arch regs base..base+N-1
//   restore_last_o    : final beat for this thread

module amt_smt_restore
  import amt_smt_restore_pkg::*;
#(
  parameter int C_RT_NUM            = RT_NUM,
  parameter int C_ARCH_REG_NUM      = ARCH_REG_NUM,
  parameter int C_TAG_IDX_WIDTH     = TAG_IDX_WIDTH,
  parameter int C_THREAD_NUM        = THREAD_NUM,
  parameter int C_THREAD_IDX_WIDTH  = THREAD_IDX_WIDTH,
  parameter int C_ARCH_IDX_WIDTH    = ARCH_IDX_WIDTH,
  parameter int C_RESTORE_PER_CYCLE = RESTORE_PER_CYCLE
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  ROB_AMT                        rob_amt_i [C_THREAD_NUM][C_RT_NUM],
  input  logic [C_THREAD_NUM-1:0]       rollback_i,
  output AMT_OUTPUT                     amt_o [C_THREAD_NUM][C_ARCH_REG_NUM],
  output logic [C_THREAD_NUM-1:0]       thread_busy_o,
  output logic                          restore_valid_o,
  input  logic                          restore_ready_i,
  output logic [C_THREAD_IDX_WIDTH-1:0] restore_thread_o,
  output logic [C_ARCH_IDX_WIDTH-1:0]   restore_base_o,
  output AMT_ENTRY                      restore_tag_o [C_RESTORE_PER_CYCLE],
  output logic                          restore_last_o
);

  localparam int BEATS  = C_ARCH_REG_NUM / C_RESTORE_PER_CYCLE;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // The port types come from the package, so the width parameters must agree.
  if ((C_ARCH_REG_NUM % C_RESTORE_PER_CYCLE) != 0) begin : g_bad_beat_size
    $error("C_RESTORE_PER_CYCLE must divide C_ARCH_REG_NUM");
  end
  if ((C_TAG_IDX_WIDTH != TAG_IDX_WIDTH) || (C_ARCH_IDX_WIDTH != ARCH_IDX_WIDTH) ||
      (C_RESTORE_PER_CYCLE != RESTORE_PER_CYCLE) ||
      (C_THREAD_IDX_WIDTH != THREAD_IDX_WIDTH)) begin : g_bad_widths
    $error("width parameters disagree with amt_smt_restore_pkg");
  end

  restore_state_e                state_q, state_d;
  logic [C_THREAD_NUM-1:0]       pending_q, pending_d;
  logic [C_THREAD_IDX_WIDTH-1:0] thr_q, thr_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;

  logic [C_THREAD_NUM-1:0]       req_all;
  logic [C_THREAD_NUM-1:0]       thr_mask;
  logic                          stream_vld;
  logic                          stream_last;
  logic                          fire;
  logic [C_ARCH_IDX_WIDTH-1:0]   base_idx;
  AMT_RESTORE_BEAT               beat;
  logic                          retire_hit;

  function automatic logic [C_THREAD_IDX_WIDTH-1:0] lowest_set(
    input logic [C_THREAD_NUM-1:0] vec);
    lowest_set = '0;
    for (int t = C_THREAD_NUM - 1; t >= 0; t--) begin
      if (vec[t]) lowest_set = C_THREAD_IDX_WIDTH'(t);
    end
  endfunction

  for (genvar t = 0; t < C_THREAD_NUM; t++) begin : g_bank
    amt_smt_restore_bank #(
      .C_RT_NUM       (C_RT_NUM),
      .C_ARCH_REG_NUM (C_ARCH_REG_NUM),
      .C_THREAD_ID    (t)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .wr_i    (rob_amt_i[t]),
      .entry_o (amt_o[t])
    );
  end

  // Same-cycle requests are folded in so the FSM can leave IDLE immediately;
  // the table write from that cycle lands before the first beat is read.
  assign req_all     = pending_q | rollback_i;
  assign thr_mask    = C_THREAD_NUM'(1) << thr_q;
  assign stream_vld  = (state_q == RST_STREAM);
  assign stream_last = stream_vld && (beat_q == LAST_BEAT);
  assign fire        = stream_vld && restore_ready_i;
  assign base_idx    = C_ARCH_IDX_WIDTH'(int'(beat_q) * C_RESTORE_PER_CYCLE);

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    beat_d    = beat_q;
    pending_d = req_all;
    case (state_q)
      RST_IDLE: begin
        if (|req_all) begin
          state_d = RST_STREAM;
          thr_d   = lowest_set(req_all);
          beat_d  = '0;
        end
      end
      RST_STREAM: begin
        if (fire) begin
          if (stream_last) begin
            // A request for the thread just finished is merged, not replayed.
            pending_d = req_all & ~thr_mask;
            beat_d    = '0;
            if (|pending_d) begin
              thr_d = lowest_set(pending_d);
            end else begin
              state_d = RST_IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = RST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RST_IDLE;
      pending_q <= '0;
      thr_q     <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      thr_q     <= thr_d;
      beat_q    <= beat_d;
    end
  end

  // Beat fields are zero when idle; tags are read live from the selected bank.
  always_comb begin
    beat = '0;
    if (stream_vld) begin
      beat.thread = thr_q;
      beat.base   = base_idx;
      beat.last   = stream_last;
      for (int j = 0; j < C_RESTORE_PER_CYCLE; j++) begin
        beat.tag[j] = amt_o[thr_q][C_ARCH_IDX_WIDTH'(int'(base_idx) + j)];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < C_RESTORE_PER_CYCLE; j++) begin
      restore_tag_o[j] = beat.tag[j];
    end
  end

  assign thread_busy_o    = pending_q;
  assign restore_valid_o  = stream_vld;
  assign restore_thread_o = beat.thread;
  assign restore_base_o   = beat.base;
  assign restore_last_o   = beat.last;

  // Retiring into the thread being streamed would make already-sent beats stale.
  always_comb begin
    retire_hit = 1'b0;
    for (int c = 0; c < C_RT_NUM; c++) begin
      if (stream_vld && rob_amt_i[thr_q][c].wr_en && (rob_amt_i[thr_q][c].arch_reg != '0)) begin
        retire_hit = 1'b1;
      end
    end
  end

  a_no_retire_while_streaming: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) !retire_hit);

endmodule

// File: tb/tb_amt_smt_restore.sv
module tb_amt_smt_restore;
  import amt_smt_restore_pkg::*;

  localparam int NT = 2;
  localparam int NA = 32;
  localparam int NB = 8;
  localparam int TW = 6;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  ROB_AMT         rob [NT][RT_NUM];
  logic [NT-1:0]  rollback;
  AMT_OUTPUT      amt [NT][NA];
  logic [NT-1:0]  busy;
  logic           vld, rdy, last;
  logic [0:0]     thr;
  logic [4:0]     base;
  AMT_ENTRY       tag [NB];

  always #5 clk = ~clk;

  amt_smt_restore dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .rob_amt_i        (rob),
    .rollback_i       (rollback),
    .amt_o            (amt),
    .thread_busy_o    (busy),
    .restore_valid_o  (vld),
    .restore_ready_i  (rdy),
    .restore_thread_o (thr),
    .restore_base_o   (base),
    .restore_tag_o    (tag),
    .restore_last_o   (last)
  );

  typedef struct packed {
    logic [0:0]       thr;
    logic [4:0]       base;
    logic             last;
    logic [NB*TW-1:0] tags;
  } beat_t;

  beat_t          sb [$];
  beat_t          got_b, exp_b;
  logic [TW-1:0]  mdl [NT][NA];
  int             tests = 0;
  int             fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic ROB_AMT mk(input logic w, input int a, input int p);
    ROB_AMT r;
    r.wr_en    = w;
    r.arch_reg = 5'(a);
    r.phy_reg  = 6'(p);
    return r;
  endfunction

  task automatic mdl_reset();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NA; i++)
        mdl[t][i] = (i == 0) ? '0 : TW'(i + t * (NA - 1));
  endtask

  task automatic push_stream(input int t);
    beat_t e;
    for (int k = 0; k < NA / NB; k++) begin
      e.thr  = 1'(t);
      e.base = 5'(k * NB);
      e.last = (k == NA / NB - 1);
      for (int j = 0; j < NB; j++) e.tags[j*TW +: TW] = mdl[t][k*NB + j];
      sb.push_back(e);
    end
  endtask

  task automatic cmp_tables(input string name);
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NA; i++)
        chk($sformatf("%s_amt_%0d_%0d", name, t, i), 64'(amt[t][i]), 64'(mdl[t][i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_drained"}, 64'(sb.size()), 0);
  endtask

  task automatic wait_base8(input string name);
    int n;
    n = 0;
    while (!(vld && base == 5'd8) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({name, "_reach_beat1"}, 64'(vld && base == 5'd8), 1);
  endtask

  // Scoreboard: every accepted beat is popped and compared.
  always @(negedge clk) begin
    if (rst_n && vld && rdy) begin
      got_b.thr  = thr;
      got_b.base = base;
      got_b.last = last;
      for (int j = 0; j < NB; j++) got_b.tags[j*TW +: TW] = tag[j];
      chk("beat_expected", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        chk("beat_thread", 64'(got_b.thr),  64'(exp_b.thr));
        chk("beat_base",   64'(got_b.base), 64'(exp_b.base));
        chk("beat_last",   64'(got_b.last), 64'(exp_b.last));
        chk("beat_tags",   64'(got_b.tags), 64'(exp_b.tags));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rollback = '0;
    rdy      = 1'b1;
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < RT_NUM; c++) rob[t][c] = '0;
    mdl_reset();

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_amt0_5", 64'(amt[0][5]), 5);
    chk("rst_amt1_5", 64'(amt[1][5]), 36);
    chk("rst_amt1_0", 64'(amt[1][0]), 0);
    chk("rst_valid",  64'(vld), 0);
    chk("rst_busy",   64'(busy), 0);
    chk("rst_last",   64'(last), 0);
    chk("rst_base",   64'(base), 0);
    chk("rst_tag3",   64'(tag[3]), 0);
    cmp_tables("rst");

    // Same-arch collision and dropped arch-0 write
    tick();
    rob[0][0] = mk(1'b1, 3, 40);
    rob[0][1] = mk(1'b1, 3, 41);
    tick();
    rob[0][0] = mk(1'b1, 0, 50);
    rob[0][1] = '0;
    tick();
    rob[0][0] = '0;
    mdl[0][3] = 6'd41;
    @(negedge clk);
    chk("coll_amt0_3", 64'(amt[0][3]), 41);
    chk("coll_amt0_0", 64'(amt[0][0]), 0);
    chk("coll_amt1_3", 64'(amt[1][3]), 34);
    cmp_tables("coll");

    // Rollback thread 1, ready held high
    tick();
    rollback = 2'b10;
    push_stream(1);
    @(negedge clk);
    chk("rb1_valid_early", 64'(vld), 0);
    tick();
    rollback = '0;
    @(negedge clk);
    chk("rb1_valid_c1", 64'(vld), 1);
    chk("rb1_busy_c1",  64'(busy), 2);
    chk("rb1_base0",    64'(base), 0);
    chk("rb1_tag1",     64'(tag[1]), 32);
    wait_drain("rb1");
    chk("rb1_busy_after",  64'(busy), 0);
    chk("rb1_valid_after", 64'(vld), 0);

    // Backpressure on beat at base 8
    tick();
    rollback = 2'b10;
    push_stream(1);
    tick();
    rollback = '0;
    wait_base8("bp");
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid",  64'(vld), 1);
      chk("bp_hold_base",   64'(base), 8);
      chk("bp_hold_thread", 64'(thr), 1);
      chk("bp_hold_last",   64'(last), 0);
      chk("bp_hold_tag0",   64'(tag[0]), 64'(mdl[1][8]));
    end
    @(posedge clk);
    #2 rdy = 1'b1;
    wait_drain("bp");
    chk("bp_busy_after", 64'(busy), 0);

    // Dual rollback with a same-cycle retire on thread 0
    tick();
    rollback  = 2'b11;
    rob[0][0] = mk(1'b1, 7, 60);
    mdl[0][7] = 6'd60;
    push_stream(0);
    push_stream(1);
    tick();
    rollback  = '0;
    rob[0][0] = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dual_nogap_valid", 64'(vld), 1);
      if (i == 0) begin
        chk("dual_first_thread", 64'(thr), 0);
        chk("dual_tag7_60",      64'(tag[7]), 60);
        chk("dual_busy",         64'(busy), 3);
      end
      if (i == 4) begin
        chk("dual_second_thread", 64'(thr), 1);
        chk("dual_second_base",   64'(base), 0);
      end
    end
    wait_drain("dual");
    chk("dual_busy_after", 64'(busy), 0);

    // Asynchronous reset in the middle of a stream
    tick();
    rollback = 2'b01;
    push_stream(0);
    tick();
    rollback = '0;
    wait_base8("mrst");
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid",  64'(vld), 0);
    chk("mrst_busy",   64'(busy), 0);
    chk("mrst_last",   64'(last), 0);
    chk("mrst_amt0_3", 64'(amt[0][3]), 3);
    chk("mrst_amt0_7", 64'(amt[0][7]), 7);
    sb.delete();
    mdl_reset();
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid_post", 64'(vld), 0);
    chk("mrst_busy_post",  64'(busy), 0);
    cmp_tables("mrst");
    repeat (3) @(negedge clk);
    chk("sb_empty_end", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
